// File: rtl/pipe_pkg.sv
// Shared types for pipeline stage registers.
// Used by every stage boundary in the core.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  localparam logic [15:0] NOP_INST_DEFAULT = 16'h0000;

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with skid slot,
// flush and saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PC_WIDTH   = 12,
  parameter int INST_WIDTH = 16,
  parameter logic [INST_WIDTH-1:0] NOP_INST =
    INST_WIDTH'(NOP_INST_DEFAULT),
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic [INST_WIDTH-1:0] in_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  stage_state_t state;
  stage_state_t state_nxt;

  logic [PC_WIDTH-1:0]   main_pc;
  logic [INST_WIDTH-1:0] main_inst;
  logic [PC_WIDTH-1:0]   skid_pc;
  logic [INST_WIDTH-1:0] skid_inst;

  logic in_fire;
  logic out_fire;
  logic ld_main_in;
  logic ld_main_skid;
  logic ld_skid;
  logic stall_inc;

  // Ready comes from state only, so the ready path is cut here.
  assign in_ready  = (state != TWO) & ~reset;
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Bubbles hide whatever stale data sits in the main slot.
  assign out_pc   = out_valid ? main_pc : '0;
  assign out_inst = out_valid ? main_inst : NOP_INST;

  // Next state and slot load selects.
  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nxt  = ONE;
          ld_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          ld_main_in = 1'b1;
        end else if (in_fire) begin
          state_nxt = TWO;
          ld_skid   = 1'b1;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_nxt    = ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
    end
  end

  // State register; flush empties the stage, reset wins over all.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Slot payloads; validity lives entirely in the state.
  always_ff @(posedge clk) begin
    if (ld_main_in) begin
      main_pc   <= in_pc;
      main_inst <= in_inst;
    end else if (ld_main_skid) begin
      main_pc   <= skid_pc;
      main_inst <= skid_inst;
    end
    if (ld_skid) begin
      skid_pc   <= in_pc;
      skid_inst <= in_inst;
    end
  end

  assign stall_inc = out_valid & ~out_ready & ~(&stall_cnt);

  // Saturating stall counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_inc) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector table plus
// scoreboard on delivered entries.
module tb_pipe_stage_reg;

  localparam int PW = 12;
  localparam int IW = 16;
  localparam int CW = 4;
  localparam logic [IW-1:0] NOP = 16'h0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_pc;
  logic [IW-1:0] in_inst;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_pc;
  logic [IW-1:0] out_inst;
  logic [CW-1:0] stall_cnt;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [IW-1:0] inst;
  } ent_t;

  ent_t q[$];
  int   popped;

  typedef struct {
    logic          iv;
    logic          ordy;
    logic          fl;
    logic [PW-1:0] pc;
    logic          e_ov;
    logic [PW-1:0] e_pc;
    logic          e_ir;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vt[13];

  pipe_stage_reg #(
    .PC_WIDTH(PW),
    .INST_WIDTH(IW),
    .NOP_INST(NOP),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pc(in_pc),
    .in_inst(in_inst),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_inst(out_inst),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Scoreboard bookkeeping for the coming edge, then advance.
  task automatic tick();
    ent_t e;
    #1;
    if (reset) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_expected", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          popped++;
          chk("sb_pc", 32'(out_pc), 32'(e.pc));
          chk("sb_inst", 32'(out_inst), 32'(e.inst));
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back({in_pc, in_inst});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic ordy,
                       input logic fl, input logic [PW-1:0] pc,
                       input logic [IW-1:0] inst);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_pc     = pc;
    in_inst   = inst;
  endtask

  initial begin
    vt[0]  = '{1, 1, 0, 12'h010, 1, 12'h010, 1, 4'd0};
    vt[1]  = '{1, 0, 0, 12'h011, 1, 12'h010, 0, 4'd1};
    vt[2]  = '{1, 0, 0, 12'h012, 1, 12'h010, 0, 4'd2};
    vt[3]  = '{1, 0, 0, 12'h012, 1, 12'h010, 0, 4'd3};
    vt[4]  = '{1, 1, 0, 12'h012, 1, 12'h011, 1, 4'd3};
    vt[5]  = '{1, 1, 0, 12'h012, 1, 12'h012, 1, 4'd3};
    vt[6]  = '{0, 1, 0, 12'h000, 0, 12'h000, 1, 4'd3};
    vt[7]  = '{1, 0, 0, 12'h018, 1, 12'h018, 1, 4'd3};
    vt[8]  = '{1, 0, 0, 12'h019, 1, 12'h018, 0, 4'd4};
    vt[9]  = '{1, 0, 1, 12'h020, 0, 12'h000, 1, 4'd5};
    vt[10] = '{1, 1, 0, 12'h021, 1, 12'h021, 1, 4'd5};
    vt[11] = '{1, 1, 1, 12'h022, 0, 12'h000, 1, 4'd5};
    vt[12] = '{0, 1, 0, 12'h000, 0, 12'h000, 1, 4'd5};

    popped = 0;
    reset  = 1'b1;
    drive(0, 0, 0, '0, '0);
    @(posedge clk);
    #1;
    chk("rst_in_ready_low", 32'(in_ready), 0);
    tick();
    chk("rst_in_ready_low2", 32'(in_ready), 0);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_pc", 32'(out_pc), 0);
    chk("rst_out_inst", 32'(out_inst), 32'(NOP));
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);

    // Streaming at full rate.
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, PW'(i), 16'hA000 | IW'(i));
      tick();
      if (i == 0) begin
        chk("stream_lat_valid", 32'(out_valid), 1);
        chk("stream_lat_pc", 32'(out_pc), 0);
      end
      chk("stream_in_ready", 32'(in_ready), 1);
    end
    drive(0, 1, 0, '0, '0);
    tick();
    chk("stream_popped", 32'(popped), 8);
    chk("stream_drained", 32'(q.size()), 0);
    chk("stream_empty", 32'(out_valid), 0);

    // Backpressure and flush vectors.
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].iv, vt[i].ordy, vt[i].fl, vt[i].pc,
            {4'hB, vt[i].pc});
      tick();
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid),
          32'(vt[i].e_ov));
      chk($sformatf("vec%0d_out_pc", i), 32'(out_pc),
          32'(vt[i].e_pc));
      chk($sformatf("vec%0d_out_inst", i), 32'(out_inst),
          vt[i].e_ov ? 32'({4'hB, vt[i].e_pc}) : 32'(NOP));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready),
          32'(vt[i].e_ir));
      chk($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt),
          32'(vt[i].e_cnt));
    end
    chk("vec_popped", 32'(popped), 8 + 4);

    // Saturation, flush keeps count, reset clears it.
    reset = 1'b1;
    drive(0, 0, 0, '0, '0);
    tick();
    reset = 1'b0;
    chk("sat_cleared", 32'(stall_cnt), 0);
    drive(1, 0, 0, 12'h030, 16'hC030);
    tick();
    drive(0, 0, 0, '0, '0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 9) chk("sat_mid", 32'(stall_cnt), 10);
    end
    chk("sat_top", 32'(stall_cnt), 15);
    drive(0, 0, 1, '0, '0);
    tick();
    chk("sat_flush_cnt", 32'(stall_cnt), 15);
    chk("sat_flush_valid", 32'(out_valid), 0);
    drive(0, 0, 0, '0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("sat_reset_cnt", 32'(stall_cnt), 0);

    // Reset while holding two entries.
    drive(1, 0, 0, 12'h040, 16'hD040);
    tick();
    drive(1, 0, 0, 12'h041, 16'hD041);
    tick();
    chk("two_in_ready", 32'(in_ready), 0);
    drive(1, 1, 0, 12'h042, 16'hD042);
    reset = 1'b1;
    #1;
    chk("rst2_in_ready_during", 32'(in_ready), 0);
    tick();
    chk("rst2_in_ready_held", 32'(in_ready), 0);
    chk("rst2_out_valid", 32'(out_valid), 0);
    chk("rst2_out_pc", 32'(out_pc), 0);
    chk("rst2_out_inst", 32'(out_inst), 32'(NOP));
    chk("rst2_stall_cnt", 32'(stall_cnt), 0);
    reset = 1'b0;
    drive(0, 1, 0, '0, '0);
    #1;
    chk("rst2_in_ready_after", 32'(in_ready), 1);
    tick();
    chk("rst2_still_empty", 32'(out_valid), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
